// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants and types for the instruction-fetch stage and the
// pipeline registers built from the same template.
//   INSTR_W / ADDR_W  : instruction and byte-address widths (32)
//   NOP_INSTR         : encoding placed in a flushed / empty pipeline slot
//   DEFAULT_RESET_PC  : default PC loaded on reset
//   ifid_t            : contents of the IF/ID pipeline register
//   pc_sel_e          : next-PC selection (run / hold / redirect)
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_STEP          = 32'd4;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc4;
    } ifid_t;

    // Empty slot: what reset and flush both leave behind.
    localparam ifid_t IFID_EMPTY = '{
        valid: 1'b0,
        instr: NOP_INSTR,
        pc:    '0,
        pc4:   '0
    };

    typedef enum logic [1:0] {
        PC_RUN      = 2'd0,
        PC_HOLD     = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    // Instructions are word aligned; low two address bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ---------------------------------------------------------------------------
// fetch_stage_ifid_reg
// IF/ID pipeline register with hold and clear controls. Also serves as the
// template for the later pipeline registers.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (register empties)
//   i_hold   in   keep current contents (stall)
//   i_clear  in   empty the register (flush); wins over i_hold
//   i_d      in   next contents when neither hold nor clear
//   o_q      out  current contents
// ---------------------------------------------------------------------------
module fetch_stage_ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_hold,
    input  logic  i_clear,
    input  ifid_t i_d,
    output ifid_t o_q
);

    ifid_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= IFID_EMPTY;
        end else if (i_clear) begin
            r_q <= IFID_EMPTY;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives the instruction-memory read
// address and captures the returned word into the IF/ID register.
// Parameters:
//   RESET_PC        PC loaded on reset (word aligned)
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   stall           in   hold PC, IF/ID and fetch counter
//   redirect_valid  in   taken branch/jump: load redirect_pc, flush IF/ID
//   redirect_pc     in   redirect target (low two bits ignored)
//   imem_addr       out  instruction-memory byte address (= pc)
//   imem_rdata      in   instruction word at imem_addr (same-cycle read)
//   pc              out  current fetch PC
//   ifid_valid      out  IF/ID holds a real instruction
//   ifid_instr      out  latched instruction (NOP when not valid)
//   ifid_pc         out  PC of the latched instruction
//   ifid_pc4        out  ifid_pc + 4
//   fetch_count     out  instructions latched valid since reset (wraps)
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic [31:0]        fetch_count
);

    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_fetch_count;

    pc_sel_e           w_pc_sel;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_redirect_target;
    ifid_t             w_ifid_d;
    ifid_t             w_ifid_q;

    // Redirect outranks stall: a taken branch must not be lost because the
    // hazard unit happens to be holding the front end in the same cycle.
    always_comb begin
        w_pc_sel = PC_RUN;
        if (redirect_valid) begin
            w_pc_sel = PC_REDIRECT;
        end else if (stall) begin
            w_pc_sel = PC_HOLD;
        end
    end

    assign w_pc_plus4        = r_pc + PC_STEP;
    assign w_redirect_target = word_align(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            case (w_pc_sel)
                PC_REDIRECT: r_pc <= w_redirect_target;
                PC_HOLD:     r_pc <= r_pc;
                default:     r_pc <= w_pc_plus4;
            endcase
        end
    end

    // Only a real fetch (neither flushed nor held) counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_pc_sel == PC_RUN) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign w_ifid_d = '{
        valid: 1'b1,
        instr: imem_rdata,
        pc:    r_pc,
        pc4:   w_pc_plus4
    };

    fetch_stage_ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_pc_sel == PC_HOLD),
        .i_clear (w_pc_sel == PC_REDIRECT),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign pc          = r_pc;
    assign imem_addr   = r_pc;
    assign ifid_valid  = w_ifid_q.valid;
    assign ifid_instr  = w_ifid_q.instr;
    assign ifid_pc     = w_ifid_q.pc;
    assign ifid_pc4    = w_ifid_q.pc4;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] imem_addr, imem_rdata, pc, ifid_instr, ifid_pc, ifid_pc4, fetch_count;
    logic        ifid_valid;

    // Second instance: wrap-around reset PC, free running.
    logic        stall1, redir1;
    logic [31:0] rpc1;
    logic [31:0] imem_addr1, imem_rdata1, pc1, ifid_instr1, ifid_pc1, ifid_pc41, fetch_count1;
    logic        ifid_valid1;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    assign imem_rdata  = mem[imem_addr[9:2]];
    assign imem_rdata1 = mem[imem_addr1[9:2]];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc(pc), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall1), .redirect_valid(redir1),
        .redirect_pc(rpc1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .pc(pc1), .ifid_valid(ifid_valid1), .ifid_instr(ifid_instr1), .ifid_pc(ifid_pc1),
        .ifid_pc4(ifid_pc41), .fetch_count(fetch_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural view of the stage. The PC is the
    // address of the next word to fetch; the IF/ID slot is either empty or
    // the record {word, address} of the last fetch; the counter is the
    // number of completed fetches.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    <= 32'h0;
            m_valid <= 1'b0;
            m_instr <= 32'h0;
            m_ipc   <= 32'h0;
            m_count <= 32'h0;
        end else if (redirect_valid) begin
            m_pc    <= redirect_pc - (redirect_pc % 4);
            m_valid <= 1'b0;
            m_instr <= 32'h0;
            m_ipc   <= 32'h0;
        end else if (!stall) begin
            m_valid <= 1'b1;
            m_instr <= mem[m_pc[9:2]];
            m_ipc   <= m_pc;
            m_pc    <= m_pc + 32'd4;
            m_count <= m_count + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pc",          pc,          m_pc);
            cmp("imem_addr",   imem_addr,   m_pc);
            cmp("ifid_valid",  {31'b0, ifid_valid}, {31'b0, m_valid});
            cmp("ifid_instr",  ifid_instr,  m_instr);
            cmp("ifid_pc",     ifid_pc,     m_ipc);
            cmp("ifid_pc4",    ifid_pc4,    m_valid ? m_ipc + 32'd4 : 32'h0);
            cmp("fetch_count", fetch_count, m_count);
        end
    end

    task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic e_valid,
                            input logic [31:0] e_instr, input logic [31:0] e_ipc,
                            input logic [31:0] e_pc4, input logic [31:0] e_cnt);
        cmp({tag, ".pc"},    pc,          e_pc);
        cmp({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, e_valid});
        cmp({tag, ".instr"}, ifid_instr,  e_instr);
        cmp({tag, ".ifpc"},  ifid_pc,     e_ipc);
        cmp({tag, ".pc4"},   ifid_pc4,    e_pc4);
        cmp({tag, ".count"}, fetch_count, e_cnt);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        stall1 = 1'b0; redir1 = 1'b0; rpc1 = 32'h0;

        repeat (2) @(negedge clk);
        chk_ifid("reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        cmp("wrap.reset_pc", pc1, 32'hFFFF_FFF8);
        chk_en = 1;
        rst = 1'b0;

        @(negedge clk);
        chk_ifid("run1", 32'h4, 1'b1, 32'h100, 32'h0, 32'h4, 32'd1);
        cmp("wrap.pc1",    pc1,         32'hFFFF_FFFC);
        cmp("wrap.ifpc1",  ifid_pc1,    32'hFFFF_FFF8);
        cmp("wrap.instr1", ifid_instr1, 32'h1FE);
        @(negedge clk);
        chk_ifid("run2", 32'h8, 1'b1, 32'h101, 32'h4, 32'h8, 32'd2);
        cmp("wrap.pc2",    pc1,         32'h0);
        cmp("wrap.ifpc2",  ifid_pc1,    32'hFFFF_FFFC);
        cmp("wrap.pc4_2",  ifid_pc41,   32'h0);
        cmp("wrap.instr2", ifid_instr1, 32'h1FF);

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_ifid("stall", 32'h8, 1'b1, 32'h101, 32'h4, 32'h8, 32'd2);
        end
        stall = 1'b0;
        @(negedge clk);
        chk_ifid("resume", 32'hC, 1'b1, 32'h102, 32'h8, 32'hC, 32'd3);

        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
        @(negedge clk);
        chk_ifid("flush", 32'h40, 1'b0, 32'h0, 32'h0, 32'h0, 32'd3);
        stall = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk_ifid("target", 32'h44, 1'b1, 32'h110, 32'h40, 32'h44, 32'd4);
        @(negedge clk);
        chk_ifid("run5", 32'h48, 1'b1, 32'h111, 32'h44, 32'h48, 32'd5);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        chk_ifid("async_rst", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        cmp("async_rst.imem_addr", imem_addr, 32'h0);
        cmp("async_rst.wrap_pc",   pc1,       32'hFFFF_FFF8);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_ifid("restart", 32'h4, 1'b1, 32'h100, 32'h0, 32'h4, 32'd1);

        // Randomized phase, checked every cycle against the model.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            @(negedge clk);
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
